// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared widths, escape constant and FSM state type for the Mandelbrot pixel engine
package mandel_pkg;

    // Default Q4.28 fixed-point format: 1.0 == 32'h1000_0000
    localparam int MANDEL_DATA_W = 32;
    localparam int MANDEL_FRAC_W = 28;
    localparam int MANDEL_ITER_W = 16;

    // Escape radius squared as an integer; scaled by 2*FRAC_W at product precision
    localparam int ESCAPE_R2 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } mandel_state_t;

endpackage

// File: rtl/mandel_fxmul.sv
// rtl/mandel_fxmul.sv - signed DATA_W x DATA_W -> 2*DATA_W combinational multiply
//
// Ports:
//   a, b : signed DATA_W operands
//   p    : full-precision signed 2*DATA_W product
module mandel_fxmul #(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;

    // Sign-extend both operands to the product width so the multiply is exact
    assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/mandel_pixel.sv
// rtl/mandel_pixel.sv - iterates z = z^2 + c for one point and reports its escape count
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : compute request, sampled only in IDLE
//   c_re, c_im        : signed fixed-point point coordinates
//   max_iter          : unsigned iteration limit
//   busy              : high whenever not IDLE
//   ready             : one-cycle pulse when iter_count/escaped are fresh
//   iter_count        : escape count of the last completed point
//   escaped           : 1 = escaped, 0 = limit reached
module mandel_pixel
    import mandel_pkg::*;
#(
    parameter int DATA_W = MANDEL_DATA_W,
    parameter int FRAC_W = MANDEL_FRAC_W,
    parameter int ITER_W = MANDEL_ITER_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] c_re,
    input  logic [DATA_W-1:0] c_im,
    input  logic [ITER_W-1:0] max_iter,
    output logic              busy,
    output logic              ready,
    output logic [ITER_W-1:0] iter_count,
    output logic              escaped
);

    localparam int PW = 2 * DATA_W;

    // 4.0 at full product precision (2*FRAC_W fraction bits), one guard bit wide
    localparam logic signed [PW:0] THRESH = (PW + 1)'(ESCAPE_R2) <<< (2 * FRAC_W);

    mandel_state_t state, state_n;

    logic signed [DATA_W-1:0] c_re_q, c_im_q;
    logic        [ITER_W-1:0] max_q;
    logic signed [DATA_W-1:0] zr, zi;
    logic        [ITER_W-1:0] n;
    logic        [ITER_W-1:0] iter_q;
    logic                     esc_q;

    logic signed [PW-1:0] sq_re, sq_im, p_x;
    logic signed [PW:0]   mag2, diff;
    logic                 esc_hit, at_limit;
    logic        [DATA_W-1:0] zr_next, zi_next;
    logic                 unused_bits;

    mandel_fxmul #(.DATA_W(DATA_W)) u_mul_rr (.a(zr), .b(zr), .p(sq_re));
    mandel_fxmul #(.DATA_W(DATA_W)) u_mul_ii (.a(zi), .b(zi), .p(sq_im));
    mandel_fxmul #(.DATA_W(DATA_W)) u_mul_ri (.a(zr), .b(zi), .p(p_x));

    // One guard bit keeps the sum and difference of two squares exact
    assign mag2 = {sq_re[PW-1], sq_re} + {sq_im[PW-1], sq_im};
    assign diff = {sq_re[PW-1], sq_re} - {sq_im[PW-1], sq_im};

    assign esc_hit  = (mag2 > THRESH);
    assign at_limit = (n == max_q);

    // Shift right by FRAC_W then wrap to DATA_W; the doubling of zr*zi folds
    // into a one-bit-smaller shift
    assign zr_next = diff[FRAC_W +: DATA_W] + c_re_q;
    assign zi_next = p_x[FRAC_W-1 +: DATA_W] + c_im_q;

    assign unused_bits = ^{diff, p_x};

    assign busy       = (state != IDLE);
    assign ready      = (state == DONE);
    assign iter_count = iter_q;
    assign escaped    = esc_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ITER;
            ITER:    if (esc_hit || at_limit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            c_re_q <= '0;
            c_im_q <= '0;
            max_q  <= '0;
            zr     <= '0;
            zi     <= '0;
            n      <= '0;
            iter_q <= '0;
            esc_q  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        c_re_q <= c_re;
                        c_im_q <= c_im;
                        max_q  <= max_iter;
                        zr     <= '0;
                        zi     <= '0;
                        n      <= '0;
                    end
                end
                ITER: begin
                    // Escape wins over the limit when both hold in the same cycle
                    if (esc_hit) begin
                        iter_q <= n;
                        esc_q  <= 1'b1;
                    end else if (at_limit) begin
                        iter_q <= n;
                        esc_q  <= 1'b0;
                    end else begin
                        zr <= zr_next;
                        zi <= zi_next;
                        n  <= n + ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandel_pixel.sv
// tb/tb_mandel_pixel.sv - directed self-checking bench for mandel_pixel
module tb_mandel_pixel;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] c_re;
    logic [31:0] c_im;
    logic [15:0] max_iter;
    logic        busy;
    logic        ready;
    logic [15:0] iter_count;
    logic        escaped;

    int total;
    int bad;

    mandel_pixel dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .c_re       (c_re),
        .c_im       (c_im),
        .max_iter   (max_iter),
        .busy       (busy),
        .ready      (ready),
        .iter_count (iter_count),
        .escaped    (escaped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one point, measure edges from acceptance to ready, check results
    task automatic run_point(input string tag, input logic [31:0] cr, input logic [31:0] ci,
                             input logic [15:0] mi, input int exp_n, input logic exp_e);
        int lat;
        @(negedge clk);
        c_re = cr; c_im = ci; max_iter = mi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!ready && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_n + 1));
        chk({tag, "_iter"}, 32'(iter_count), 32'(exp_n));
        chk({tag, "_esc"}, 32'(escaped), 32'(exp_e));
        @(posedge clk); #1;
        chk({tag, "_pulse1"}, 32'(ready), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int cyc;
        int pos[$];
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; c_re = '0; c_im = '0; max_iter = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_ready", 32'(ready),      32'd0);
        chk("rst_iter",  32'(iter_count), 32'd0);
        chk("rst_esc",   32'(escaped),    32'd0);
        @(negedge clk); reset = 1'b0;

        run_point("c0",    32'h0000_0000, 32'h0, 16'd100, 100, 1'b0);
        run_point("c1",    32'h1000_0000, 32'h0, 16'd100, 3,   1'b1);
        run_point("cm2",   32'hE000_0000, 32'h0, 16'd50,  50,  1'b0);
        run_point("c3",    32'h3000_0000, 32'h0, 16'd100, 1,   1'b1);

        // Results hold while idle
        repeat (5) @(posedge clk);
        #1;
        chk("hold_iter", 32'(iter_count), 32'd1);
        chk("hold_esc",  32'(escaped),    32'd1);

        run_point("mi0",   32'h0000_0000, 32'h0, 16'd0,   0,   1'b0);

        // Reset mid-iteration after an escaped point so outputs are non-zero first
        run_point("pre",   32'h3000_0000, 32'h0, 16'd100, 1,   1'b1);
        @(negedge clk);
        c_re = 32'h0; c_im = 32'h0; max_iter = 16'd100; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_busy",  32'(busy),       32'd0);
        chk("mid_ready", 32'(ready),      32'd0);
        chk("mid_iter",  32'(iter_count), 32'd0);
        chk("mid_esc",   32'(escaped),    32'd0);
        @(negedge clk); reset = 1'b0;
        pulses = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        run_point("post",  32'h1000_0000, 32'h0, 16'd100, 3,   1'b1);

        // Back-to-back with start held: accept at edge 1, ready at 5, 11, 17
        @(negedge clk);
        c_re = 32'h1000_0000; c_im = 32'h0; max_iter = 16'd100; start = 1'b1;
        cyc = 0;
        repeat (30) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 17) start = 1'b0;
            if (ready) begin
                pos.push_back(cyc);
                chk($sformatf("b2b_iter_%0d", cyc), 32'(iter_count), 32'd3);
            end
            if (cyc == 6 || cyc == 12 || cyc == 18)
                chk($sformatf("b2b_idle_%0d", cyc), 32'(busy), 32'd0);
            if (cyc == 7 || cyc == 13)
                chk($sformatf("b2b_reaccept_%0d", cyc), 32'(busy), 32'd1);
        end
        chk("b2b_count", 32'(pos.size()), 32'd3);
        if (pos.size() == 3) begin
            chk("b2b_pos0", 32'(pos[0]), 32'd5);
            chk("b2b_pos1", 32'(pos[1]), 32'd11);
            chk("b2b_pos2", 32'(pos[2]), 32'd17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
